// File: rtl/ps2_key_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_key_receiver
// Purpose  : PS/2 keyboard frame receiver. Synchronises the raw PS/2 lines,
//            deserialises 11-bit frames (start, 8 data LSB first, odd parity,
//            stop), validates them and presents each accepted scan byte with
//            a one-cycle sample strike. Optional filtering of release codes
//            (0xF0 and the byte following it).
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_receiver #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_BREAK   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_reg,
    output logic       sample,
    output logic       frame_err,
    output logic       busy
);

    localparam int                 c_CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TO_MAX     = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]         c_BREAK_CODE = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Synchroniser and edge-history flops
    logic               r_clkMeta;
    logic               r_clkSync;
    logic               r_clkPrev;
    logic               r_dataMeta;
    logic               r_dataSync;

    // Frame assembly
    state_t             r_state;
    logic [2:0]         r_bitCnt;
    logic [7:0]         r_shreg;
    logic               r_parity;
    logic               r_stopBit;
    logic               r_commit;
    logic               r_busy;
    logic [c_CNT_W-1:0] r_toCnt;

    // Commit stage outputs
    logic [7:0]         r_keyReg;
    logic               r_sample;
    logic               r_frameErr;
    logic               r_breakPending;

    logic               w_fall;
    logic               w_timeout;
    logic               w_frameOk;

    assign w_fall    = r_clkPrev & ~r_clkSync;
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_toCnt == c_TO_MAX);
    // Odd parity: data plus parity bit must hold an odd number of ones.
    assign w_frameOk = r_stopBit & (^{r_shreg, r_parity});

    assign key_reg   = r_keyReg;
    assign sample    = r_sample;
    assign frame_err = r_frameErr;
    assign busy      = r_busy;

    // Bring the asynchronous PS/2 lines into the clock domain and keep clock history.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clkMeta  <= 1'b1;
            r_clkSync  <= 1'b1;
            r_clkPrev  <= 1'b1;
            r_dataMeta <= 1'b1;
            r_dataSync <= 1'b1;
        end else begin
            r_clkMeta  <= ps2_clk;
            r_clkSync  <= r_clkMeta;
            r_clkPrev  <= r_clkSync;
            r_dataMeta <= ps2_data;
            r_dataSync <= r_dataMeta;
        end
    end

    // Frame state machine: advances on each PS/2 falling edge, aborts on inter-edge timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bitCnt  <= 3'd0;
            r_shreg   <= 8'h00;
            r_parity  <= 1'b0;
            r_stopBit <= 1'b0;
            r_commit  <= 1'b0;
            r_busy    <= 1'b0;
            r_toCnt   <= '0;
        end else begin
            r_commit <= 1'b0;

            // Timeout counter measures the gap since the last falling edge mid-frame.
            if (w_fall || (r_state == S_IDLE)) begin
                r_toCnt <= '0;
            end else if (r_toCnt != c_TO_MAX) begin
                r_toCnt <= r_toCnt + 1'b1;
            end

            if (w_timeout) begin
                // Stalled frame: drop it silently.
                r_state  <= S_IDLE;
                r_bitCnt <= 3'd0;
                r_busy   <= 1'b0;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        // A high data line here is a stray edge, not a start bit.
                        if (!r_dataSync) begin
                            r_state  <= S_DATA;
                            r_bitCnt <= 3'd0;
                            r_busy   <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shreg <= {r_dataSync, r_shreg[7:1]};
                        if (r_bitCnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                        end
                    end
                    S_PARITY: begin
                        r_parity <= r_dataSync;
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        r_stopBit <= r_dataSync;
                        r_commit  <= 1'b1;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Commit a completed frame: flag errors, filter release codes, or publish the byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_keyReg       <= 8'h00;
            r_sample       <= 1'b0;
            r_frameErr     <= 1'b0;
            r_breakPending <= 1'b0;
        end else begin
            r_sample   <= 1'b0;
            r_frameErr <= 1'b0;
            if (r_commit) begin
                if (!w_frameOk) begin
                    r_frameErr <= 1'b1;
                end else if ((FILTER_BREAK != 0) && (r_shreg == c_BREAK_CODE)) begin
                    r_breakPending <= 1'b1;
                end else if ((FILTER_BREAK != 0) && r_breakPending) begin
                    // Byte following 0xF0 is the released key; swallow it.
                    r_breakPending <= 1'b0;
                end else begin
                    r_keyReg <= r_shreg;
                    r_sample <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
